window3_feeder: RTL and testbench
=================================

# window3_feeder

Stream-side producer for the 3-tap signed multiply-accumulate stage. It accepts a row-framed stream of 10-bit signed activations and holds three 10-bit signed weights. Each cycle it can present a complete tap set (x0..x2, w0..w2, clip) from a registered, valid/ready-handshaked output directly to the MAC. It sits between the activation buffer and the product-sum stage in the convolution datapath.

## Interface
- DW, 10, sample and weight width (two's complement)
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid && in_ready
- in_data  in  DW  signed activation
- in_last  in  1  marks last sample of a row
- w_load  in  1  weight write strobe
- w_sel  in  2  weight index 0..2; 3 ignored
- w_data  in  DW  signed weight
- clip_cfg  in  1  clip mode to forward to MAC
- out_valid  out  1  tap set valid
- out_ready  in  1  downstream accepts tap set
- x0, x1, x2  out  DW  signed taps, x0 oldest sample
- w0, w1, w2  out  DW  signed weights captured with the window
- clip  out  1  clip_cfg captured with the window

## Operation
- Internal state: two history registers h1 (newest), h0 (previous); a row sample counter cnt saturating at 2; a weight bank wb[0..2]; an output register {x0..x2, w0..w2, clip, out_valid}.
- FSM states: FILL (cnt<2 in current row), STREAM (cnt==2), TAIL (PAD_EN only, pending right-edge window).
- in_ready = (state != TAIL) && (!out_valid || out_ready).
- On accepted sample s:
  - STREAM: emit (h0, h1, s). FILL: no emit, except with PAD_EN and cnt==1, which emits (0, h1, s).
  - Shift h0<=h1, h1<=s, cnt<=min(cnt+1,2).
- If in_last is set on the accepted sample:
  - Without PAD_EN: cnt<=0, histories cleared, next state FILL.
  - With PAD_EN: next state TAIL.
- TAIL: when !out_valid || out_ready, emit (h0 if row had ≥2 samples else 0, h1, 0), clear cnt and histories, go to FILL.
- Output count per row of N samples: N-2 without PAD_EN (0 if N<3); N with PAD_EN (N≥1).
- Emit loads the output register with the taps, wb[0..2], clip_cfg, and sets out_valid. out_valid clears on out_ready without a new emit. Emit and drain in the same cycle keeps out_valid at 1.
- Weight writes:
  - w_load writes wb[w_sel] on the same edge; w_sel==3 is a no-op.
  - A write in the same cycle as an emit: the emitted window carries the old weight. The new weight applies from the next emit.
- Output register holds stable while out_valid && !out_ready, including w0..w2 and clip.
- No arithmetic; samples pass through bit-exact, and pad value is 0.

## Timing
- Reset values: out_valid=0, x0..x2=0, w0..w2=0, clip=0, wb=0, cnt=0, state FILL. in_ready is 1 after reset.
- Latency: window appears on outputs the cycle after the completing sample is accepted.
- Throughput: one window per cycle under continuous in_valid and out_ready.
- PAD_EN adds exactly one in_ready=0 bubble per row (TAIL), longer only if out_ready is low.
- resetn assertion mid-row or mid-TAIL discards partial row and pending output immediately (asynchronous).
- Back-pressure never drops or duplicates a window.

## Configuration
- WINDOW3_PAD_EN defined: zero padding at row edges, TAIL state present, N outputs per row.
- Undefined: valid-only windows, no TAIL state, N-2 outputs per row, and in_ready depends only on the output register.

## Structure
- Shared package cnn_pkg: DW constant, signed sample typedef, FSM state enum (FILL, STREAM, TAIL).
- One sub-module, coef_bank3: three DW registers with w_load/w_sel write port and parallel read; reset to 0.
- FSM, history, and output register live in the top module.

## Test plan
- Weights: load w=(1,-2,3), clip_cfg=1, out_ready=1. Then row 5,6,7,8 with last on 8. Without PAD: expect (5,6,7) then (6,7,8), w=(1,-2,3), clip=1.
- Same row with WINDOW3_PAD_EN: expect (0,5,6), (5,6,7), (6,7,8), (7,8,0). in_ready is low exactly one cycle after 8.
- Edge rows: row of 2 samples 10,-11 without PAD gives no output. With PAD it gives (0,10,-11), (10,-11,0). One-sample row 4 with PAD gives (0,4,0).
- Back-pressure: hold out_ready=0 for 3 cycles after first emit. Outputs stay stable, in_ready stays low, and no window is lost.
- Weight update: write w_sel=1 to -512 in the same cycle a window emits. That window shows old w1 and the next shows -512. A write with w_sel=3 changes nothing.
- Mid-stream reset: assert resetn low after 2 samples. All outputs return to 0 and out_valid=0. The next row starts fresh, with no stale history in the first window.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared convolution datapath types: sample width, signed sample,
// window feeder FSM states and the tap-set bundle handed to the MAC.
package cnn_pkg;

  localparam int DW = 10;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    TAIL   = 2'd2
  } state_t;

  typedef struct packed {
    sample_t x0;
    sample_t x1;
    sample_t x2;
    sample_t w0;
    sample_t w1;
    sample_t w2;
    logic    clip;
  } taps_t;

endpackage

// File: rtl/window3_feeder_if.sv
// Stream-in / tap-set-out handshake bundle of the 3-tap window feeder.
// slave is the feeder's view, master the producer/consumer side.
interface window3_feeder_if;
  import cnn_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  logic    in_last;

  logic    out_valid;
  logic    out_ready;
  sample_t x0;
  sample_t x1;
  sample_t x2;
  sample_t w0;
  sample_t w1;
  sample_t w2;
  logic    clip;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output x0,
    output x1,
    output x2,
    output w0,
    output w1,
    output w2,
    output clip
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  x0,
    input  x1,
    input  x2,
    input  w0,
    input  w1,
    input  w2,
    input  clip
  );

endinterface

// File: rtl/coef_bank3.sv
// Three signed weight registers with a single indexed write port;
// index 3 is ignored.
module coef_bank3
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       w_load,
  input  logic [1:0] w_sel,
  input  sample_t    w_data,
  output sample_t    w0,
  output sample_t    w1,
  output sample_t    w2
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (w_load) begin
      case (w_sel)
        2'd0:    w0 <= w_data;
        2'd1:    w1 <= w_data;
        2'd2:    w2 <= w_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/window3_feeder.sv
// Row-framed 3-sample window producer for the 3-tap MAC.
// Define WINDOW3_PAD_EN for zero padding at row edges (adds TAIL state).
module window3_feeder
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             w_load,
  input  logic [1:0]       w_sel,
  input  sample_t          w_data,
  input  logic             clip_cfg,
  window3_feeder_if.slave  s
);

`ifdef WINDOW3_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  state_t     state;
  state_t     state_n;
  sample_t    h0;
  sample_t    h1;
  sample_t    h0_n;
  sample_t    h1_n;
  logic [1:0] cnt;
  logic [1:0] cnt_n;

  taps_t      oq;
  logic       ov;

  sample_t    wb0;
  sample_t    wb1;
  sample_t    wb2;

  logic       can_out;
  logic       acc;
  logic       emit;
  sample_t    e0;
  sample_t    e1;
  sample_t    e2;

  coef_bank3 u_bank (
    .clk    (clk),
    .resetn (resetn),
    .w_load (w_load),
    .w_sel  (w_sel),
    .w_data (w_data),
    .w0     (wb0),
    .w1     (wb1),
    .w2     (wb2)
  );

  assign can_out = !ov || s.out_ready;

`ifdef WINDOW3_PAD_EN
  assign s.in_ready = (state != TAIL) && can_out;
`else
  assign s.in_ready = can_out;
`endif

  assign acc = s.in_valid && s.in_ready;

  always_comb begin
    state_n = state;
    h0_n    = h0;
    h1_n    = h1;
    cnt_n   = cnt;
    emit    = 1'b0;
    e0      = '0;
    e1      = '0;
    e2      = '0;
    if (acc) begin
      if (state == STREAM) begin
        emit = 1'b1;
        e0   = h0;
        e1   = h1;
        e2   = s.in_data;
      end else if (PAD && cnt == 2'd1) begin
        emit = 1'b1;
        e1   = h1;
        e2   = s.in_data;
      end
      h0_n    = h1;
      h1_n    = s.in_data;
      cnt_n   = (cnt == 2'd2) ? 2'd2 : cnt + 2'd1;
      state_n = (cnt_n == 2'd2) ? STREAM : FILL;
      if (s.in_last) begin
        if (PAD) begin
          // keep history; TAIL emits the right-edge window next
          state_n = TAIL;
        end else begin
          state_n = FILL;
          h0_n    = '0;
          h1_n    = '0;
          cnt_n   = '0;
        end
      end
    end else if (PAD && state == TAIL && can_out) begin
      emit    = 1'b1;
      e0      = (cnt == 2'd2) ? h0 : '0;
      e1      = h1;
      state_n = FILL;
      h0_n    = '0;
      h1_n    = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= FILL;
      h0    <= '0;
      h1    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      h0    <= h0_n;
      h1    <= h1_n;
      cnt   <= cnt_n;
    end
  end

  // bank is read before this edge's write, so a same-cycle update lands next window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oq <= '0;
      ov <= 1'b0;
    end else if (emit) begin
      oq <= {e0, e1, e2, wb0, wb1, wb2, clip_cfg};
      ov <= 1'b1;
    end else if (s.out_ready) begin
      ov <= 1'b0;
    end
  end

  assign s.out_valid = ov;
  assign s.x0        = oq.x0;
  assign s.x1        = oq.x1;
  assign s.x2        = oq.x2;
  assign s.w0        = oq.w0;
  assign s.w1        = oq.w1;
  assign s.w2        = oq.w2;
  assign s.clip      = oq.clip;

endmodule

// File: tb/tb_window3_feeder.sv
// Scoreboard bench for window3_feeder; expected windows are queued at
// stimulus time and popped by a monitor on each output handshake.
module tb_window3_feeder;
  import cnn_pkg::*;

`ifdef WINDOW3_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       w_load = 1'b0;
  logic [1:0] w_sel = 2'd0;
  sample_t    w_data = '0;
  logic       clip_cfg = 1'b0;

  window3_feeder_if io ();

  window3_feeder dut (
    .clk      (clk),
    .resetn   (resetn),
    .w_load   (w_load),
    .w_sel    (w_sel),
    .w_data   (w_data),
    .clip_cfg (clip_cfg),
    .s        (io.slave)
  );

  always #5 clk = ~clk;

  int      passed = 0;
  int      total = 0;
  taps_t   expq[$];
  sample_t ew0 = '0;
  sample_t ew1 = '0;
  sample_t ew2 = '0;
  logic    eclip = 1'b0;

  function automatic taps_t cur_taps();
    return {io.x0, io.x1, io.x2, io.w0, io.w1, io.w2, io.clip};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int a, input int b, input int c);
    taps_t t;
    t.x0   = sample_t'(a);
    t.x1   = sample_t'(b);
    t.x2   = sample_t'(c);
    t.w0   = ew0;
    t.w1   = ew1;
    t.w2   = ew2;
    t.clip = eclip;
    expq.push_back(t);
  endtask

  always @(negedge clk) begin : monitor
    taps_t got;
    taps_t e;
    if (resetn && io.out_valid && io.out_ready) begin
      got = cur_taps();
      total++;
      if (expq.size() == 0) begin
        $display("FAIL window: unexpected (%0d,%0d,%0d) none expected",
                 got.x0, got.x1, got.x2);
      end else begin
        e = expq.pop_front();
        if (got === e) passed++;
        else $display({"FAIL window: got x=(%0d,%0d,%0d) w=(%0d,%0d,%0d) c=%0d",
                       " expected x=(%0d,%0d,%0d) w=(%0d,%0d,%0d) c=%0d"},
                      got.x0, got.x1, got.x2, got.w0, got.w1, got.w2, got.clip,
                      e.x0, e.x1, e.x2, e.w0, e.w1, e.w2, e.clip);
      end
    end
  end

  task automatic send(input int d, input bit last, input bit wl = 1'b0,
                      input logic [1:0] sel = 2'd0, input int wd = 0);
    int n;
    io.in_valid = 1'b1;
    io.in_data  = sample_t'(d);
    io.in_last  = last;
    w_load      = wl;
    w_sel       = sel;
    w_data      = sample_t'(wd);
    n = 0;
    while (!io.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    w_load      = 1'b0;
  endtask

  task automatic wload(input logic [1:0] sel, input int d);
    w_load = 1'b1;
    w_sel  = sel;
    w_data = sample_t'(d);
    @(posedge clk);
    #1;
    w_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("queue drained", expq.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    taps_t snap;
    int    n;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("reset out_valid", io.out_valid, 0);
    chk("reset taps", int'(cur_taps() == '0), 1);
    chk("reset in_ready", io.in_ready, 1);

    // basic row with weights (1,-2,3), clip on
    wload(2'd0, 1);
    wload(2'd1, -2);
    wload(2'd2, 3);
    clip_cfg = 1'b1;
    ew0 = 1; ew1 = -2; ew2 = 3; eclip = 1'b1;
    if (PAD) push(0, 5, 6);
    push(5, 6, 7);
    push(6, 7, 8);
    if (PAD) push(7, 8, 0);
    send(5, 0); send(6, 0); send(7, 0); send(8, 1);
    chk("in_ready after last", io.in_ready, PAD ? 0 : 1);
    @(posedge clk);
    #1;
    chk("in_ready bubble end", io.in_ready, 1);

    // short rows
    if (PAD) begin
      push(0, 10, -11);
      push(10, -11, 0);
    end
    send(10, 0); send(-11, 1);
    if (PAD) push(0, 4, 0);
    send(4, 1);
    drain();

    // back-pressure right after the first emit
    io.out_ready = 1'b0;
    if (PAD) push(0, 5, 6);
    push(5, 6, 7);
    push(6, 7, 8);
    if (PAD) push(7, 8, 0);
    fork
      begin
        send(5, 0); send(6, 0); send(7, 0); send(8, 1);
      end
      begin
        n = 0;
        while (!io.out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp first emit", io.out_valid, 1);
        snap = cur_taps();
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("bp stable", int'(cur_taps() === snap), 1);
          chk("bp out_valid held", io.out_valid, 1);
          chk("bp in_ready low", io.in_ready, 0);
        end
        io.out_ready = 1'b1;
      end
    join
    drain();

    // weight write in the same cycle as an emit
    if (PAD) push(0, 1, 2);
    push(1, 2, 3);
    ew1 = -512;
    push(2, 3, 4);
    if (PAD) push(3, 4, 0);
    send(1, 0); send(2, 0); send(3, 0, 1'b1, 2'd1, -512); send(4, 1);
    drain();

    // w_sel 3 must not alter the bank
    wload(2'd3, 77);
    if (PAD) push(0, -1, -2);
    push(-1, -2, 511);
    if (PAD) push(-2, 511, 0);
    send(-1, 0); send(-2, 0); send(511, 1);
    drain();

    // reset partway into a row
    send(30, 0); send(31, 0);
    resetn = 1'b0;
    #1;
    chk("midrst out_valid", io.out_valid, 0);
    chk("midrst taps", int'(cur_taps() == '0), 1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("midrst in_ready", io.in_ready, 1);
    ew0 = 0; ew1 = 0; ew2 = 0;
    if (PAD) push(0, 20, 21);
    push(20, 21, 22);
    if (PAD) push(21, 22, 0);
    send(20, 0); send(21, 0); send(22, 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
